// File: rtl/clock_pkg.sv
// Shared constants for the calendar stage: field-select codes, reset date, year limit and port widths.
package clock_pkg;

  localparam int DAY_W   = 5;
  localparam int MONTH_W = 4;
  localparam int YEAR_W  = 14;

  localparam logic [1:0] FIELD_DAY   = 2'd0;
  localparam logic [1:0] FIELD_MONTH = 2'd1;
  localparam logic [1:0] FIELD_YEAR  = 2'd2;
  localparam logic [1:0] FIELD_NONE  = 2'd3;

  localparam logic [YEAR_W-1:0]  YEAR_MAX  = 14'd9999;
  localparam logic [DAY_W-1:0]   RST_DAY   = 5'd1;
  localparam logic [MONTH_W-1:0] RST_MONTH = 4'd1;
  localparam logic [YEAR_W-1:0]  RST_YEAR  = 14'd2000;

  // Limit a day value to the length of the month it will live in.
  function automatic logic [DAY_W-1:0] clamp_day(input logic [DAY_W-1:0] day,
                                                 input logic [DAY_W-1:0] dim);
    clamp_day = (day > dim) ? dim : day;
  endfunction

endpackage

// File: rtl/month_len.sv
// Days-in-month lookup with leap-year evaluation.
// Define LEAP_GREGORIAN_EN for the full Gregorian rule; otherwise every year divisible by 4 is leap.
module month_len
  import clock_pkg::*;
(
  input  logic [MONTH_W-1:0] month,
  input  logic [YEAR_W-1:0]  year,
  output logic [DAY_W-1:0]   dim
);

  logic leap_s;

`ifdef LEAP_GREGORIAN_EN
  assign leap_s = ((year[1:0] == 2'd0) && ((year % 14'd100) != 14'd0)) ||
                  ((year % 14'd400) == 14'd0);
`else
  assign leap_s = (year[1:0] == 2'd0);
`endif

  // Month length lookup
  always_comb begin
    dim = 5'd31;
    case (month)
      4'd2:    dim = leap_s ? 5'd29 : 5'd28;
      4'd4,
      4'd6,
      4'd9,
      4'd11:   dim = 5'd30;
      default: dim = 5'd31;
    endcase
  end

endmodule

// File: rtl/date_counter.sv
// Day/month/year calendar counter fed by the hour stage, with manual field adjust in set mode.
// Leap-year rule selected by LEAP_GREGORIAN_EN (see month_len).
module date_counter
  import clock_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               dec,
  input  logic               ctrl_set,
  input  logic [1:0]         sel_field,
  input  logic               carry_in_hour,
  output logic [DAY_W-1:0]   day_count,
  output logic [MONTH_W-1:0] month_count,
  output logic [YEAR_W-1:0]  year_count,
  output logic               carry_out
);

  logic [DAY_W-1:0]   day_q, day_d, day_raw_s;
  logic [MONTH_W-1:0] month_q, month_d;
  logic [YEAR_W-1:0]  year_q, year_d;
  logic [DAY_W-1:0]   dim_cur_s, dim_new_s;

  month_len u_len_cur (.month(month_q), .year(year_q), .dim(dim_cur_s));
  // Length of the month the date is moving into, used to clamp the day after month/year edits.
  month_len u_len_new (.month(month_d), .year(year_d), .dim(dim_new_s));

  // Next-date computation: run-mode advance or set-mode field adjust
  always_comb begin
    day_raw_s = day_q;
    month_d   = month_q;
    year_d    = year_q;
    if (!ctrl_set) begin
      if (carry_in_hour) begin
        if (day_q < dim_cur_s) begin
          day_raw_s = day_q + 5'd1;
        end else begin
          day_raw_s = 5'd1;
          if (month_q < 4'd12) begin
            month_d = month_q + 4'd1;
          end else begin
            month_d = 4'd1;
            year_d  = (year_q >= YEAR_MAX) ? 14'd0 : year_q + 14'd1;
          end
        end
      end else begin
        day_raw_s = day_q;
      end
    end else if (inc || dec) begin
      case (sel_field)
        FIELD_DAY: begin
          if (inc) begin
            day_raw_s = (day_q >= dim_cur_s) ? 5'd1 : day_q + 5'd1;
          end else begin
            day_raw_s = (day_q <= 5'd1) ? dim_cur_s : day_q - 5'd1;
          end
        end
        FIELD_MONTH: begin
          if (inc) begin
            month_d = (month_q >= 4'd12) ? 4'd1 : month_q + 4'd1;
          end else begin
            month_d = (month_q <= 4'd1) ? 4'd12 : month_q - 4'd1;
          end
        end
        FIELD_YEAR: begin
          if (inc) begin
            year_d = (year_q >= YEAR_MAX) ? 14'd0 : year_q + 14'd1;
          end else begin
            year_d = (year_q == 14'd0) ? YEAR_MAX : year_q - 14'd1;
          end
        end
        default: begin
          day_raw_s = day_q;
        end
      endcase
    end else begin
      day_raw_s = day_q;
    end
    day_d = clamp_day(day_raw_s, dim_new_s);
  end

  // Date registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      day_q   <= RST_DAY;
      month_q <= RST_MONTH;
      year_q  <= RST_YEAR;
    end else begin
      day_q   <= day_d;
      month_q <= month_d;
      year_q  <= year_d;
    end
  end

  assign day_count   = day_q;
  assign month_count = month_q;
  assign year_count  = year_q;

  assign carry_out = ~rst & carry_in_hour & ~ctrl_set & (day_q == 5'd31) &
                     (month_q == 4'd12) & (year_q == YEAR_MAX);

endmodule

// File: tb/tb_date_counter.sv
// Directed self-checking bench for date_counter; dates are loaded through set mode.
module tb_date_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inc = 1'b0;
  logic        dec = 1'b0;
  logic        ctrl_set = 1'b0;
  logic [1:0]  sel_field = 2'd3;
  logic        carry_in_hour = 1'b0;
  logic [4:0]  day_count;
  logic [3:0]  month_count;
  logic [13:0] year_count;
  logic        carry_out;

  int total = 0;
  int bad = 0;

  date_counter dut (
    .clk(clk), .rst(rst), .inc(inc), .dec(dec), .ctrl_set(ctrl_set),
    .sel_field(sel_field), .carry_in_hour(carry_in_hour),
    .day_count(day_count), .month_count(month_count), .year_count(year_count),
    .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_date(input string tag, input int y, input int m, input int d);
    chk({tag, ".year"}, int'(year_count), y);
    chk({tag, ".month"}, int'(month_count), m);
    chk({tag, ".day"}, int'(day_count), d);
  endtask

  // One set-mode inc/dec pulse on the currently selected field.
  task automatic step(input bit i_v, input bit d_v);
    @(negedge clk);
    inc = i_v;
    dec = d_v;
    @(posedge clk);
    #1;
    inc = 1'b0;
    dec = 1'b0;
  endtask

  // One hour-stage tick; carry_out is sampled before the edge.
  task automatic tick(input string tag, input bit exp_co);
    @(negedge clk);
    carry_in_hour = 1'b1;
    #1;
    chk({tag, ".carry_out"}, int'(carry_out), int'(exp_co));
    @(posedge clk);
    #1;
    carry_in_hour = 1'b0;
  endtask

  task automatic set_date(input int y, input int m, input int d);
    int up;
    int n;
    ctrl_set = 1'b1;
    sel_field = 2'd2;
    up = (y - int'(year_count) + 10000) % 10000;
    if (up <= 5000) begin
      for (int k = 0; k < up; k++) step(1'b1, 1'b0);
    end else begin
      for (int k = 0; k < 10000 - up; k++) step(1'b0, 1'b1);
    end
    sel_field = 2'd1;
    n = (m - int'(month_count) + 12) % 12;
    for (int k = 0; k < n; k++) step(1'b1, 1'b0);
    sel_field = 2'd0;
    for (int k = 0; k < 32 && int'(day_count) != d; k++) step(1'b1, 1'b0);
    sel_field = 2'd3;
    ctrl_set = 1'b0;
    chk_date("load", y, m, d);
  endtask

  initial begin
    // Reset state while rst is held
    #12;
    chk_date("reset", 2000, 1, 1);
    chk("reset.carry_out", int'(carry_out), 0);
    @(negedge clk);
    rst = 1'b0;

    // Plain month roll
    set_date(2023, 2, 28);
    tick("feb23", 1'b0);
    chk_date("feb23", 2023, 3, 1);

    // Century leap rule
    set_date(2100, 2, 28);
    tick("feb2100", 1'b0);
`ifdef LEAP_GREGORIAN_EN
    chk_date("feb2100", 2100, 3, 1);
`else
    chk_date("feb2100", 2100, 2, 29);
`endif
    set_date(2000, 2, 28);
    tick("feb2000", 1'b0);
    chk_date("feb2000", 2000, 2, 29);

    // Millennium rollover, first blocked by set mode
    set_date(9999, 12, 31);
    ctrl_set = 1'b1;
    tick("blocked", 1'b0);
    chk_date("blocked", 9999, 12, 31);
    ctrl_set = 1'b0;
    tick("rollover", 1'b1);
    chk_date("rollover", 0, 1, 1);
    chk("rollover.co_after", int'(carry_out), 0);

    // Month then year adjust with day clamp
    set_date(2024, 1, 31);
    ctrl_set = 1'b1;
    sel_field = 2'd1;
    step(1'b1, 1'b0);
    chk_date("mon_inc", 2024, 2, 29);
    sel_field = 2'd2;
    step(1'b1, 1'b0);
    chk_date("yr_inc", 2025, 2, 28);
    sel_field = 2'd1;
    for (int k = 0; k < 2; k++) step(1'b0, 1'b1);
    chk_date("mon_dec_wrap", 2025, 12, 28);
    ctrl_set = 1'b0;

    // Day adjust in April
    set_date(2024, 4, 1);
    ctrl_set = 1'b1;
    sel_field = 2'd0;
    step(1'b1, 1'b1);
    chk_date("inc_prio", 2024, 4, 2);
    step(1'b0, 1'b1);
    chk_date("day_dec", 2024, 4, 1);
    step(1'b0, 1'b1);
    chk_date("day_dec_wrap", 2024, 4, 30);
    step(1'b1, 1'b0);
    chk_date("day_inc_wrap", 2024, 4, 1);
    sel_field = 2'd3;
    step(1'b1, 1'b0);
    chk_date("no_field", 2024, 4, 1);
    ctrl_set = 1'b0;
    // inc/dec must be ignored outside set mode
    sel_field = 2'd0;
    step(1'b1, 1'b0);
    chk_date("run_inc", 2024, 4, 1);
    sel_field = 2'd3;

    // Asynchronous reset between edges
    tick("pre_rst", 1'b0);
    chk_date("pre_rst", 2024, 4, 2);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_date("async_rst", 2000, 1, 1);
    chk("async_rst.carry_out", int'(carry_out), 0);
    @(negedge clk);
    rst = 1'b0;
    tick("post_rst", 1'b0);
    chk_date("post_rst", 2000, 1, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
